// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer
//   Time-multiplexed controller for one fully-connected layer. A single shared
//   multiply-accumulate path is walked across every neuron: bias fetch, then
//   N_IN input/weight pairs, then a thresholded result bit offered on a
//   ready/valid port. All ROM/buffer reads have a fixed 1-cycle latency.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a layer pass (honoured only when idle)
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   x_addr, x_data        input-vector buffer read port
//   w_addr, w_data        weight ROM read port (address n*N_IN + i)
//   b_addr, b_data        bias ROM read port (address n)
//   y_valid, y_ready      result handshake
//   y_idx, y_bit, y_sum   neuron index, activation bit, raw sum of the result
//   y_vec                 activation bits of all neurons, latched on handshake
module neuron_layer_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter logic signed [DATA_W-1:0] THRESHOLD = '0,
  localparam int X_AW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int W_AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int N_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [X_AW-1:0]          x_addr,
  input  logic signed [DATA_W-1:0] x_data,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [N_AW-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [N_AW-1:0]          y_idx,
  output logic                     y_bit,
  output logic signed [DATA_W-1:0] y_sum,
  output logic [N_OUT-1:0]         y_vec
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_EMIT, S_DONE} state_t;

  localparam logic [X_AW-1:0] K_LAST = X_AW'(N_IN - 1);
  localparam logic [N_AW-1:0] N_LAST = N_AW'(N_OUT - 1);

  // Product keeps only the low DATA_W bits; the add wraps modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] mac_wrap(
    input logic signed [DATA_W-1:0] base,
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [DATA_W-1:0] prod;
    prod = x * w;
    return base + prod;
  endfunction

  function automatic logic activate(input logic signed [DATA_W-1:0] s);
    return s > THRESHOLD;
  endfunction

  state_t                   state_q;
  logic [N_AW-1:0]          n_q;
  logic [X_AW-1:0]          k_q;
  logic signed [DATA_W-1:0] acc_q;
  logic signed [DATA_W-1:0] acc_d;
  logic                     busy_q;
  logic                     done_q;
  logic                     y_valid_q;
  logic [N_AW-1:0]          y_idx_q;
  logic                     y_bit_q;
  logic signed [DATA_W-1:0] y_sum_q;
  logic [N_OUT-1:0]         y_vec_q;
  logic [X_AW-1:0]          x_addr_q;
  logic [W_AW-1:0]          w_addr_q;
  logic [N_AW-1:0]          b_addr_q;

  // The first MAC beat seeds the sum with the bias instead of the running total.
  always_comb begin
    acc_d = mac_wrap((k_q == '0) ? b_data : acc_q, x_data, w_data);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_idx_q   <= '0;
      y_bit_q   <= 1'b0;
      y_sum_q   <= '0;
      y_vec_q   <= '0;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_BIAS;
            busy_q   <= 1'b1;
            n_q      <= '0;
            y_vec_q  <= '0;
            x_addr_q <= '0;
            w_addr_q <= '0;
            b_addr_q <= '0;
          end
        end
        // Addresses run one beat ahead of the data they select.
        S_BIAS: begin
          state_q <= S_MAC;
          k_q     <= '0;
          if (N_IN > 1) begin
            x_addr_q <= x_addr_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_q == K_LAST) begin
            state_q   <= S_EMIT;
            y_valid_q <= 1'b1;
            y_idx_q   <= n_q;
            y_sum_q   <= acc_d;
            y_bit_q   <= activate(acc_d);
          end else begin
            k_q <= k_q + 1'b1;
            if (int'(k_q) + 2 < N_IN) begin
              x_addr_q <= x_addr_q + 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end
        end
        // Addresses hold during a stall; the next row starts right after the
        // last weight of this one, so increments reach n*N_IN directly.
        S_EMIT: begin
          if (y_ready) begin
            y_valid_q     <= 1'b0;
            y_vec_q[n_q]  <= y_bit_q;
            if (n_q == N_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_BIAS;
              n_q      <= n_q + 1'b1;
              x_addr_q <= '0;
              w_addr_q <= w_addr_q + 1'b1;
              b_addr_q <= b_addr_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          x_addr_q <= '0;
          w_addr_q <= '0;
          b_addr_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_addr  = x_addr_q;
  assign w_addr  = w_addr_q;
  assign b_addr  = b_addr_q;
  assign y_valid = y_valid_q;
  assign y_idx   = y_idx_q;
  assign y_bit   = y_bit_q;
  assign y_sum   = y_sum_q;
  assign y_vec   = y_vec_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: two instances (N_IN=4/N_OUT=2/THRESHOLD=0
// and N_IN=1/N_OUT=2/THRESHOLD=10) against a schedule-level reference model.
module tb_neuron_layer_sequencer;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn[2], start[2], rdy[2];
  logic [DW-1:0] xd[2], wd[2], bd[2];

  logic          busy0, done0, yv0, ybit0, yidx0, ba0;
  logic [1:0]    xa0, yvec0;
  logic [2:0]    wa0;
  logic [DW-1:0] ysum0;
  logic          busy1, done1, yv1, ybit1, yidx1, ba1, xa1, wa1;
  logic [1:0]    yvec1;
  logic [DW-1:0] ysum1;

  neuron_layer_sequencer #(.N_IN(4), .N_OUT(2), .DATA_W(DW), .THRESHOLD(0)) dut0 (
    .clk(clk), .rst_n(rstn[0]), .start(start[0]), .busy(busy0), .done(done0),
    .x_addr(xa0), .x_data(xd[0]), .w_addr(wa0), .w_data(wd[0]),
    .b_addr(ba0), .b_data(bd[0]), .y_valid(yv0), .y_ready(rdy[0]),
    .y_idx(yidx0), .y_bit(ybit0), .y_sum(ysum0), .y_vec(yvec0));

  neuron_layer_sequencer #(.N_IN(1), .N_OUT(2), .DATA_W(DW), .THRESHOLD(10)) dut1 (
    .clk(clk), .rst_n(rstn[1]), .start(start[1]), .busy(busy1), .done(done1),
    .x_addr(xa1), .x_data(xd[1]), .w_addr(wa1), .w_data(wd[1]),
    .b_addr(ba1), .b_data(bd[1]), .y_valid(yv1), .y_ready(rdy[1]),
    .y_idx(yidx1), .y_bit(ybit1), .y_sum(ysum1), .y_vec(yvec1));

  int   o_xa[2], o_wa[2], o_ba[2], o_idx[2], o_sum[2], o_vec[2];
  logic o_busy[2], o_done[2], o_yv[2], o_bit[2];
  always_comb begin
    o_xa[0] = int'(xa0);   o_wa[0] = int'(wa0);   o_ba[0] = int'(ba0);
    o_idx[0] = int'(yidx0); o_sum[0] = int'(ysum0); o_vec[0] = int'(yvec0);
    o_busy[0] = busy0; o_done[0] = done0; o_yv[0] = yv0; o_bit[0] = ybit0;
    o_xa[1] = int'(xa1);   o_wa[1] = int'(wa1);   o_ba[1] = int'(ba1);
    o_idx[1] = int'(yidx1); o_sum[1] = int'(ysum1); o_vec[1] = int'(yvec1);
    o_busy[1] = busy1; o_done[1] = done1; o_yv[1] = yv1; o_bit[1] = ybit1;
  end

  // Memories with one cycle of read latency.
  logic [DW-1:0] xrom[2][4];
  logic [DW-1:0] wrom[2][8];
  logic [DW-1:0] brom[2][2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      xd[d] <= xrom[d][o_xa[d]];
      wd[d] <= wrom[d][o_wa[d]];
      bd[d] <= brom[d][o_ba[d]];
    end
  end

  int NIN[2]  = '{4, 1};
  int NOUT[2] = '{2, 2};
  int THR[2]  = '{0, 10};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic signed [31:0] a, input logic signed [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, a, a, e, e, $time);
    end
  endtask

  function automatic int model_sum(input int d, input int nn);
    int s;
    s = int'(brom[d][nn]);
    for (int i = 0; i < NIN[d]; i++)
      s += int'(xrom[d][i]) * int'(wrom[d][nn * NIN[d] + i]);
    return s;
  endfunction

  // Reference model: cycle index c counts from the accepted start edge.
  bit   act[2]     = '{0, 0};
  bit   fresh[2]   = '{1, 1};
  int   c[2], nidx[2], emit_at[2], done_at[2];
  int   first_v[2] = '{-1, -1};
  int   done_rel[2] = '{-1, -1};
  int   ndone[2]   = '{0, 0};
  int   nlog[2]    = '{0, 0};
  int   es[2][2];
  bit   eb[2][2];
  bit   vec[2][2];
  int   logs[2][8];
  bit   logb[2][8];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (act[d]) begin
        if (o_yv[d] && first_v[d] < 0) first_v[d] = c[d];
        if (o_done[d]) done_rel[d] = c[d];
      end
      if (o_done[d]) ndone[d]++;
      if (!rstn[d]) begin
        act[d] = 0; fresh[d] = 1;
        vec[d][0] = 0; vec[d][1] = 0;
      end else if (!act[d]) begin
        if (start[d]) begin
          act[d] = 1; c[d] = 1; nidx[d] = 0;
          emit_at[d] = NIN[d] + 2; done_at[d] = -1;
          vec[d][0] = 0; vec[d][1] = 0;
          first_v[d] = -1; done_rel[d] = -1; nlog[d] = 0;
          for (int nn = 0; nn < NOUT[d]; nn++) begin
            es[d][nn] = model_sum(d, nn);
            eb[d][nn] = (es[d][nn] > THR[d]);
          end
        end
      end else begin
        if (c[d] == done_at[d]) act[d] = 0;
        else if (c[d] >= emit_at[d]) begin
          fresh[d] = 0;
          if (rdy[d]) begin
            vec[d][nidx[d]] = eb[d][nidx[d]];
            if (nlog[d] < 8) begin
              logs[d][nlog[d]] = o_sum[d];
              logb[d][nlog[d]] = o_bit[d];
              nlog[d]++;
            end
            if (nidx[d] == NOUT[d] - 1) done_at[d] = c[d] + 1;
            else begin
              nidx[d]++;
              emit_at[d] = c[d] + NIN[d] + 2;
            end
          end
        end
        c[d]++;
      end
    end
  end

  always @(negedge clk) begin
    int ev, ebusy, edone, exa, ewa, eba, chka, j, xi, evec;
    for (int d = 0; d < 2; d++) begin
      ev = 0; ebusy = 0; edone = 0; exa = 0; ewa = 0; eba = 0; chka = 1;
      if (act[d]) begin
        ebusy = 1;
        if (c[d] == done_at[d]) begin
          edone = 1; chka = 0;
        end else begin
          if (c[d] >= emit_at[d]) begin
            ev = 1; xi = NIN[d] - 1;
          end else begin
            j = c[d] - (emit_at[d] - (NIN[d] + 1));
            xi = (j < NIN[d] - 1) ? j : NIN[d] - 1;
          end
          eba = nidx[d]; exa = xi; ewa = nidx[d] * NIN[d] + xi;
        end
      end
      evec = int'(vec[d][0]) + 2 * int'(vec[d][1]);
      chk($sformatf("busy%0d", d), o_busy[d], ebusy);
      chk($sformatf("done%0d", d), o_done[d], edone);
      chk($sformatf("y_valid%0d", d), o_yv[d], ev);
      chk($sformatf("y_vec%0d", d), o_vec[d], evec);
      if (chka) begin
        chk($sformatf("x_addr%0d", d), o_xa[d], exa);
        chk($sformatf("w_addr%0d", d), o_wa[d], ewa);
        chk($sformatf("b_addr%0d", d), o_ba[d], eba);
      end
      if (ev) begin
        chk($sformatf("y_idx%0d", d), o_idx[d], nidx[d]);
        chk($sformatf("y_sum%0d", d), o_sum[d], es[d][nidx[d]]);
        chk($sformatf("y_bit%0d", d), o_bit[d], eb[d][nidx[d]]);
      end
      if (!act[d] && fresh[d]) begin
        chk($sformatf("rst_idx%0d", d), o_idx[d], 0);
        chk($sformatf("rst_sum%0d", d), o_sum[d], 0);
        chk($sformatf("rst_bit%0d", d), o_bit[d], 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int d, input bit rr);
    start[d] = 1'b1; step(); start[d] = 1'b0;
    for (int t = 0; t < 300 && !o_done[d]; t++) begin
      if (rr) rdy[d] = 1'($urandom_range(0, 1));
      step();
    end
    chk($sformatf("pass_done_seen%0d", d), o_done[d], 1);
    rdy[d] = 1'b1; step(); step();
  endtask

  task automatic load_basic0();
    for (int i = 0; i < 4; i++) begin
      xrom[0][i]     = DW'(i + 1);
      wrom[0][i]     = 32'd1;
      wrom[0][4 + i] = 32'hFFFF_FFFF;
    end
    brom[0][0] = 32'd0; brom[0][1] = 32'd5;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    if ($urandom_range(0, 1) == 0) return $urandom;
    return DW'($signed($urandom_range(0, 20)) - 10);
  endfunction

  task automatic load_random(input int d);
    for (int i = 0; i < 4; i++) xrom[d][i] = rnd_word();
    for (int i = 0; i < 8; i++) wrom[d][i] = rnd_word();
    for (int i = 0; i < 2; i++) brom[d][i] = rnd_word();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; start[d] = 1'b0; rdy[d] = 1'b1;
      for (int i = 0; i < 4; i++) xrom[d][i] = '0;
      for (int i = 0; i < 8; i++) wrom[d][i] = '0;
      for (int i = 0; i < 2; i++) brom[d][i] = '0;
    end
    repeat (3) step();
    chk("reset_busy0", o_busy[0], 0);
    chk("reset_yvec0", o_vec[0], 0);
    chk("reset_ysum1", o_sum[1], 0);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    step();

    // Basic two-neuron pass.
    load_basic0();
    chk("model_sum_n0", model_sum(0, 0), 10);
    chk("model_sum_n1", model_sum(0, 1), -5);
    run_pass(0, 0);
    chk("basic_first_valid", first_v[0], 6);
    chk("basic_done_cycle", done_rel[0], 13);
    chk("basic_nresults", nlog[0], 2);
    chk("basic_sum0", logs[0][0], 10);
    chk("basic_sum1", logs[0][1], -5);
    chk("basic_bit0", logb[0][0], 1);
    chk("basic_bit1", logb[0][1], 0);
    chk("basic_yvec", o_vec[0], 1);

    // Threshold boundary on the N_IN=1 instance (THRESHOLD=10).
    xrom[1][0] = 32'd1; wrom[1][0] = 32'd0; wrom[1][1] = 32'd0;
    brom[1][0] = 32'd10; brom[1][1] = 32'd11;
    chk("model_thr_eq", model_sum(1, 0), 10);
    run_pass(1, 0);
    chk("thr_first_valid", first_v[1], 3);
    chk("thr_done_cycle", done_rel[1], 7);
    chk("thr_sum_eq", logs[1][0], 10);
    chk("thr_bit_eq", logb[1][0], 0);
    chk("thr_sum_above", logs[1][1], 11);
    chk("thr_bit_above", logb[1][1], 1);
    chk("thr_yvec", o_vec[1], 2);

    // Wrapping product and accumulation.
    xrom[1][0] = 32'h7FFF_FFFF; wrom[1][0] = 32'd2; brom[1][0] = 32'd0;
    wrom[1][1] = 32'd1; brom[1][1] = 32'd1;
    run_pass(1, 0);
    chk("ovf_sum0", logs[1][0], 32'hFFFF_FFFE);
    chk("ovf_bit0", logb[1][0], 0);
    chk("ovf_sum1", logs[1][1], 32'h8000_0000);
    chk("ovf_yvec", o_vec[1], 0);

    // Three cycles of backpressure on neuron 0.
    load_basic0();
    rdy[0] = 1'b0;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    for (int t = 0; t < 50 && !o_yv[0]; t++) step();
    chk("bp_valid_seen", o_yv[0], 1);
    repeat (3) step();
    rdy[0] = 1'b1;
    for (int t = 0; t < 50 && !o_done[0]; t++) step();
    chk("bp_done_seen", o_done[0], 1);
    step(); step();
    chk("bp_first_valid", first_v[0], 6);
    chk("bp_done_cycle", done_rel[0], 16);

    // start pulses during MAC and during DONE are ignored.
    load_random(0);
    base = ndone[0];
    start[0] = 1'b1; step(); start[0] = 1'b0;
    repeat (3) step();
    start[0] = 1'b1; step(); start[0] = 1'b0;
    for (int t = 0; t < 50 && !o_done[0]; t++) step();
    chk("ign_done_seen", o_done[0], 1);
    start[0] = 1'b1; step(); start[0] = 1'b0;
    repeat (3) step();
    chk("ign_done_count", ndone[0] - base, 1);
    chk("ign_nresults", nlog[0], 2);
    chk("ign_idle_busy", o_busy[0], 0);

    // Reset during MAC of neuron 1, then a clean pass.
    load_basic0();
    base = ndone[0];
    start[0] = 1'b1; step(); start[0] = 1'b0;
    repeat (8) step();
    rstn[0] = 1'b0; step(); rstn[0] = 1'b1;
    chk("mrst_busy", o_busy[0], 0);
    chk("mrst_valid", o_yv[0], 0);
    chk("mrst_yvec", o_vec[0], 0);
    chk("mrst_ysum", o_sum[0], 0);
    chk("mrst_waddr", o_wa[0], 0);
    repeat (3) step();
    chk("mrst_no_done", ndone[0] - base, 0);
    run_pass(0, 0);
    chk("mrst_nresults", nlog[0], 2);
    chk("mrst_sum0", logs[0][0], 10);
    chk("mrst_sum1", logs[0][1], -5);

    // Randomised data and random y_ready.
    for (int it = 0; it < 8; it++) begin
      load_random(0);
      load_random(1);
      run_pass(0, 1);
      chk("rand_nresults0", nlog[0], 2);
      run_pass(1, 1);
      chk("rand_nresults1", nlog[1], 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
